// File: rtl/popcount_pkg.sv
// Shared definitions for the ternary popcount accumulator.
//   state_t      : neuron sequencing states (ACCUM, DRAIN, HOLD)
//   ACT_*        : ternary activation encodings driven on out_act
//   pc_width     : popcount width for an n-bit mask
//   acc_width    : signed accumulator width that cannot overflow
//   beat_width   : width of a counter that reaches max_beats
package popcount_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] ACT_ZERO = 2'b00;
    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;

    function automatic int pc_width(input int n_in);
        return $clog2(n_in + 1);
    endfunction

    // Magnitude bound is n_in*max_beats; one extra bit carries the sign.
    function automatic int acc_width(input int n_in, input int max_beats);
        return $clog2(n_in * max_beats + 1) + 1;
    endfunction

    function automatic int beat_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Exact combinational population count.
//   vec   : input mask, N_IN bits
//   count : number of set bits in vec, PC_W bits
module popcount_tree
    import popcount_pkg::*;
#(
    parameter  int N_IN = 21,
    localparam int PC_W = pc_width(N_IN)
) (
    input  logic [N_IN-1:0] vec,
    output logic [PC_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_IN; i++) begin
            count = count + PC_W'(vec[i]);
        end
    end

endmodule

// File: rtl/popcount_ternary_acc.sv
// Sequential ternary-neuron accumulator.
// Each accepted beat contributes popcount(pos&~neg) - popcount(neg&~pos);
// beats are summed until in_last or MAX_BEATS closes the neuron, then the
// sum, beat count, truncation flag and ternary activation are presented
// with a valid/ready handshake.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : beat handshake (in_ready high only while accumulating)
//   in_pos, in_neg      : +1 / -1 masks, N_IN bits
//   in_last             : final beat of the neuron
//   thr_hi, thr_lo      : signed activation thresholds
//   out_valid/out_ready : result handshake
//   out_sum             : signed neuron sum
//   out_act             : 01 = +1, 11 = -1, 00 = 0
//   out_beats           : beats accepted for this neuron
//   out_trunc           : neuron was closed by MAX_BEATS rather than in_last
//
// Build option: define POPCOUNT_THR_EN to build the threshold comparators;
// otherwise out_act is constant 00 and the thresholds are ignored.
module popcount_ternary_acc
    import popcount_pkg::*;
#(
    parameter  int N_IN      = 21,
    parameter  int MAX_BEATS = 16,
    localparam int PC_W      = pc_width(N_IN),
    localparam int ACC_W     = acc_width(N_IN, MAX_BEATS),
    localparam int BEAT_W    = beat_width(MAX_BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN-1:0]         in_pos,
    input  logic [N_IN-1:0]         in_neg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [1:0]              out_act,
    output logic [BEAT_W-1:0]       out_beats,
    output logic                    out_trunc
);

    // ---------------- stage 1: per-beat signed contribution ----------------
    logic [N_IN-1:0]        pos_only;
    logic [N_IN-1:0]        neg_only;
    logic [PC_W-1:0]        pos_cnt;
    logic [PC_W-1:0]        neg_cnt;
    logic signed [PC_W:0]   d_next;

    // Bits set in both masks cancel, so they are removed before counting.
    assign pos_only = in_pos & ~in_neg;
    assign neg_only = in_neg & ~in_pos;

    popcount_tree #(.N_IN(N_IN)) u_pos_cnt (.vec(pos_only), .count(pos_cnt));
    popcount_tree #(.N_IN(N_IN)) u_neg_cnt (.vec(neg_only), .count(neg_cnt));

    assign d_next = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});

    // ---------------- state ----------------
    state_t                  state_reg;
    logic                    in_ready_reg;
    logic                    out_valid_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [BEAT_W-1:0]       beats_reg;
    logic signed [PC_W:0]    d_reg;
    logic                    d_valid_reg;
    logic                    d_last_reg;
    logic                    d_trunc_reg;
    logic signed [ACC_W-1:0] out_sum_reg;
    logic [1:0]              out_act_reg;
    logic [BEAT_W-1:0]       out_beats_reg;
    logic                    out_trunc_reg;

    logic                    accept;
    logic                    at_max;
    logic                    closes;
    logic                    trunc_hit;
    logic signed [ACC_W-1:0] d_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic [1:0]              act_next;

    assign accept    = in_valid && in_ready_reg;
    // The beat being accepted now is the MAX_BEATS-th one.
    assign at_max    = (beats_reg == BEAT_W'(MAX_BEATS - 1));
    assign closes    = in_last || at_max;
    // When in_last coincides with the limit the neuron closed normally.
    assign trunc_hit = at_max && !in_last;
    assign d_ext     = ACC_W'(d_reg);
    assign acc_next  = acc_reg + d_ext;

    // Activation uses the final sum: in DRAIN with no pending contribution,
    // acc_reg already holds every beat.
`ifdef POPCOUNT_THR_EN
    always_comb begin
        act_next = ACT_ZERO;
        if (acc_reg >= thr_hi) begin
            act_next = ACT_POS;
        end else if (acc_reg <= thr_lo) begin
            act_next = ACT_NEG;
        end
    end
`else
    logic unused_thr;
    assign unused_thr = ^{thr_hi, thr_lo};
    assign act_next   = ACT_ZERO;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ACCUM;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            beats_reg     <= '0;
            d_reg         <= '0;
            d_valid_reg   <= 1'b0;
            d_last_reg    <= 1'b0;
            d_trunc_reg   <= 1'b0;
            out_sum_reg   <= '0;
            out_act_reg   <= ACT_ZERO;
            out_beats_reg <= '0;
            out_trunc_reg <= 1'b0;
        end else begin
            d_valid_reg <= accept;
            if (accept) begin
                d_reg       <= d_next;
                d_last_reg  <= closes;
                d_trunc_reg <= trunc_hit;
            end

            case (state_reg)
                ACCUM: begin
                    if (d_valid_reg) begin
                        acc_reg <= acc_next;
                    end
                    if (accept) begin
                        beats_reg <= beats_reg + BEAT_W'(1);
                        if (closes) begin
                            state_reg    <= DRAIN;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle folds in the closing beat; the
                    // second publishes the completed result.
                    if (d_valid_reg && d_last_reg) begin
                        acc_reg <= acc_next;
                    end else if (!d_valid_reg) begin
                        state_reg     <= HOLD;
                        out_valid_reg <= 1'b1;
                        out_sum_reg   <= acc_reg;
                        out_act_reg   <= act_next;
                        out_beats_reg <= beats_reg;
                        out_trunc_reg <= d_trunc_reg;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg     <= ACCUM;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                        acc_reg       <= '0;
                        beats_reg     <= '0;
                    end
                end
                default: begin
                    state_reg    <= ACCUM;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_act   = out_act_reg;
    assign out_beats = out_beats_reg;
    assign out_trunc = out_trunc_reg;

endmodule

// File: tb/tb_popcount_ternary_acc.sv
// Self-checking bench for popcount_ternary_acc: a table of single-beat
// neurons, hand-written multi-beat sequences (three beats, truncation,
// backpressure, mid-neuron reset) and randomized neurons checked against
// a per-bit arithmetic model.
module tb_popcount_ternary_acc;
    import popcount_pkg::*;

    localparam int N_IN      = 21;
    localparam int MAX_BEATS = 16;
    localparam int ACC_W     = acc_width(N_IN, MAX_BEATS);
    localparam int BEAT_W    = beat_width(MAX_BEATS);
`ifdef POPCOUNT_THR_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN-1:0]         in_pos;
    logic [N_IN-1:0]         in_neg;
    logic                    in_last;
    logic signed [ACC_W-1:0] thr_hi;
    logic signed [ACC_W-1:0] thr_lo;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [1:0]              out_act;
    logic [BEAT_W-1:0]       out_beats;
    logic                    out_trunc;

    int total = 0;
    int bad   = 0;

    logic [N_IN-1:0] bq_pos[$];
    logic [N_IN-1:0] bq_neg[$];

    typedef struct {
        logic [N_IN-1:0] pos;
        logic [N_IN-1:0] neg;
        int              hi;
        int              lo;
        int              exp_sum;
        logic [1:0]      exp_act;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    popcount_ternary_acc #(.N_IN(N_IN), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_act(out_act),
        .out_beats(out_beats), .out_trunc(out_trunc)
    );

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    // Reference: walk every bit, +1 for pos-only, -1 for neg-only.
    function automatic int contrib(input logic [N_IN-1:0] p, input logic [N_IN-1:0] n);
        int s = 0;
        for (int b = 0; b < N_IN; b++) begin
            if (p[b] && !n[b]) s++;
            if (n[b] && !p[b]) s--;
        end
        return s;
    endfunction

    function automatic logic [1:0] ref_act(input int s, input int hi, input int lo);
        if (s >= hi) return 2'b01;
        if (s <= lo) return 2'b11;
        return 2'b00;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [N_IN-1:0] p, input logic [N_IN-1:0] n, input logic l);
        int guard = 0;
        in_valid = 1'b1;
        in_pos   = p;
        in_neg   = n;
        in_last  = l;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check("in_ready_timeout", 0, 1);
        end
        @(negedge clk);
    endtask

    // Sends the queued beats as one neuron and checks the result.
    task automatic run_neuron(input string tag, input bit close_last, input int hi, input int lo,
                              input int exp_sum, input logic [1:0] exp_act, input int exp_beats,
                              input bit exp_trunc, input int hold);
        int nb = bq_pos.size();
        int lat = 0;
        logic [1:0] act_w = THR_EN ? exp_act : 2'b00;
        thr_hi = ACC_W'(hi);
        thr_lo = ACC_W'(lo);
        for (int i = 0; i < nb; i++) begin
            send_beat(bq_pos[i], bq_neg[i], close_last && (i == nb - 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (lat == 0) check({tag, ":ready_in_drain"}, int'(in_ready), 0);
            @(negedge clk);
            lat++;
        end
        check({tag, ":latency"}, lat, 2);
        check({tag, ":sum"}, int'(out_sum), exp_sum);
        check({tag, ":act"}, int'(out_act), int'(act_w));
        check({tag, ":beats"}, int'(out_beats), exp_beats);
        check({tag, ":trunc"}, int'(out_trunc), int'(exp_trunc));
        $display("neuron %s: beats=%0d sum=%0d act=%b trunc=%0d", tag, out_beats, out_sum, out_act, out_trunc);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_pos   = '1;
            in_neg   = '0;
            in_last  = 1'b1;
            @(negedge clk);
            check({tag, ":hold_valid"}, int'(out_valid), 1);
            check({tag, ":hold_ready"}, int'(in_ready), 0);
            check({tag, ":hold_sum"}, int'(out_sum), exp_sum);
            check({tag, ":hold_beats"}, int'(out_beats), exp_beats);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":released_ready"}, int'(in_ready), 1);
        check({tag, ":released_valid"}, int'(out_valid), 0);
        bq_pos.delete();
        bq_neg.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pos    = '0;
        in_neg    = '0;
        in_last   = 1'b0;
        thr_hi    = '0;
        thr_lo    = '0;
        out_ready = 1'b0;

        tbl[0] = '{21'h1FFFFF, 21'h000000, 10, -10, 21, 2'b01};
        tbl[1] = '{21'h1FFFFF, 21'h1FFFFF, 1, -1, 0, 2'b00};
        tbl[2] = '{21'h000000, 21'h1FFFFF, 5, -5, -21, 2'b11};
        tbl[3] = '{21'h0000FF, 21'h00000F, 4, 4, 4, 2'b01};
        tbl[4] = '{21'h000000, 21'h000000, 0, 0, 0, 2'b01};
        tbl[5] = '{21'h100000, 21'h000001, 1, -1, 0, 2'b00};
        tbl[6] = '{21'h000005, 21'h00001A, 5, -1, -1, 2'b11};

        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_act", int'(out_act), 0);
        check("rst_out_beats", int'(out_beats), 0);
        check("rst_out_trunc", int'(out_trunc), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(in_ready), 1);
        check("post_rst_valid", int'(out_valid), 0);

        // Single-beat table.
        for (int i = 0; i < 7; i++) begin
            bq_pos.push_back(tbl[i].pos);
            bq_neg.push_back(tbl[i].neg);
            run_neuron($sformatf("tbl%0d", i), 1'b1, tbl[i].hi, tbl[i].lo,
                       tbl[i].exp_sum, tbl[i].exp_act, 1, 1'b0, 0);
        end

        // Three beats: -5, -7, +2.
        bq_pos.push_back(21'h0); bq_neg.push_back(21'h1F);
        bq_pos.push_back(21'h0); bq_neg.push_back(21'h7F);
        bq_pos.push_back(21'h3); bq_neg.push_back(21'h0);
        run_neuron("three", 1'b1, 10, -8, -10, 2'b11, 3, 1'b0, 0);

        // Truncation at MAX_BEATS, then a fresh neuron.
        for (int i = 0; i < MAX_BEATS; i++) begin
            bq_pos.push_back(21'h1);
            bq_neg.push_back(21'h0);
        end
        run_neuron("trunc", 1'b0, 16, 0, 16, 2'b01, 16, 1'b1, 0);
        bq_pos.push_back(21'h3); bq_neg.push_back(21'h0);
        run_neuron("after_trunc", 1'b1, 10, -10, 2, 2'b00, 1, 1'b0, 0);

        // Backpressure: hold out_ready low for 5 cycles.
        bq_pos.push_back(21'h0F0F0); bq_neg.push_back(21'h00F00);
        bq_pos.push_back(21'h00007); bq_neg.push_back(21'h00000);
        run_neuron("bp", 1'b1, 100, -100, 7, 2'b00, 2, 1'b0, 5);

        // Reset in the middle of a neuron.
        send_beat(21'h1FFFFF, 21'h0, 1'b0);
        send_beat(21'h1FFFFF, 21'h0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_sum", int'(out_sum), 0);
        check("midrst_beats", int'(out_beats), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", int'(in_ready), 1);
        bq_pos.push_back(21'h7); bq_neg.push_back(21'h0);
        run_neuron("after_rst", 1'b1, 3, 0, 3, 2'b01, 1, 1'b0, 0);

        // Randomized neurons against the model.
        for (int r = 0; r < 25; r++) begin
            int nb = $urandom_range(1, MAX_BEATS);
            bit cl = (nb < MAX_BEATS) || ($urandom_range(0, 2) != 0);
            int hi = $urandom_range(0, 60) - 30;
            int lo = $urandom_range(0, 60) - 30;
            int s = 0;
            for (int b = 0; b < nb; b++) begin
                logic [N_IN-1:0] p = N_IN'($urandom);
                logic [N_IN-1:0] n = N_IN'($urandom);
                bq_pos.push_back(p);
                bq_neg.push_back(n);
                s += contrib(p, n);
            end
            run_neuron($sformatf("rnd%0d", r), cl, hi, lo, s, ref_act(s, hi, lo),
                       nb, !cl, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/popcount_ternary_acc.md
# popcount_ternary_acc

Sequential ternary-neuron accumulator built on an exact parametrised popcount. Each input beat carries an N_IN-bit positive mask and an N_IN-bit negative mask, and the block accumulates the signed difference of their popcounts over a multi-beat neuron. At the final beat it emits the signed sum and an optional ternary activation. It sits between the sensor-side weight/activation unpacker and the layer output buffer, and replaces single-cycle combinational popcount cores when fan-in exceeds one word.

## Interface
- N_IN, 21, bits per beat (≥2)
- MAX_BEATS, 16, max beats per neuron (≥1)
- PC_W, derived $clog2(N_IN+1), per-mask popcount width
- ACC_W, derived $clog2(N_IN*MAX_BEATS+1)+1, signed accumulator width
- BEAT_W, derived $clog2(MAX_BEATS+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_pos  in  N_IN  +1 mask
- in_neg  in  N_IN  −1 mask
- in_last  in  1  final beat of neuron
- thr_hi  in  ACC_W  signed upper threshold
- thr_lo  in  ACC_W  signed lower threshold
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&&out_ready
- out_sum  out  ACC_W  signed accumulated sum
- out_act  out  2  ternary activation: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0
- out_beats  out  BEAT_W  beats in this neuron
- out_trunc  out  1  neuron closed by MAX_BEATS, not by in_last

## Operation
- Per-bit contribution: pos&~neg → +1; neg&~pos → −1; both or neither → 0.
- Stage 1 (registered): d = popcount(in_pos&~in_neg) − popcount(in_neg&~in_pos), signed PC_W+1 bits. Also registers d_valid, d_last, d_trunc.
- Stage 2: acc += sign-extended d. The acc is cleared at the start of each neuron. No overflow is possible by construction of ACC_W.
- FSM states:
  - ACCUM: in_ready=1. Accepting a beat with in_last=1, or accepting the MAX_BEATS-th beat, moves to DRAIN. In the MAX_BEATS case out_trunc=1.
  - DRAIN: in_ready=0. The final d is added; the next state is HOLD.
  - HOLD: out_valid=1, in_ready=0. When out_ready=1, go to ACCUM and clear acc and beat counter.
- Activation is evaluated on the DRAIN→HOLD edge from the final sum and the thr_hi/thr_lo values present on that cycle:
  - sum ≥ thr_hi → +1
  - else sum ≤ thr_lo → −1
  - else 0
  - When both conditions hold, +1 wins.
- Outputs are held stable throughout HOLD.
- Reset (any time, including mid-neuron): state=ACCUM, acc=0, beats=0, stage-1 valid=0, in_ready=1 after release. Reset values: out_valid=0, out_sum=0, out_act=0, out_beats=0, out_trunc=0. Any partial neuron is discarded.

## Timing
- Last beat accepted at edge t → out_valid=1 after edge t+2.
- A single-beat neuron gives the same latency of 2.
- Throughput: B beats per neuron costs B+2 cycles plus the HOLD dwell.
- in_ready is 1 in ACCUM only. It is never combinationally dependent on in_valid.
- out_valid is registered. out_ready is not needed for out_valid to assert.
- Minimum HOLD dwell is 1 cycle (out_ready=1 already asserted). The first beat of the next neuron can be accepted on the cycle after release.

## Configuration
- POPCOUNT_THR_EN defined: the threshold compare is built and out_act is driven as specified.
- POPCOUNT_THR_EN undefined: no comparators, out_act tied to 2'b00, thr_hi/thr_lo ignored. All other behaviour and timing are unchanged.

## Structure
- Package popcount_pkg holds:
  - state enum (ACCUM, DRAIN, HOLD)
  - activation encoding constants ACT_ZERO/ACT_POS/ACT_NEG
  - width helper functions for PC_W, ACC_W and BEAT_W
- Sub-module popcount_tree: a combinational exact popcount with parameter N_IN and output PC_W. It is instantiated twice in stage 1.

## Test plan
- Reset: with rst high, all outputs are 0 and in_ready=0 is not required. After release, in_ready=1 and out_valid=0.
- Single beat, N_IN=21: in_pos=all ones, in_neg=0, in_last=1 → out_valid 2 cycles later, out_sum=21, out_beats=1, out_trunc=0. With thr_hi=10 → out_act=01.
- Overlap cancel: in_pos=in_neg=21'h1FFFFF, in_last → out_sum=0. With thr_hi=1, thr_lo=−1 → out_act=00.
- Three beats with contributions −5, −7, +2 → out_sum=−10. With thr_lo=−8 → out_act=11. in_ready=0 during DRAIN/HOLD.
- Truncation: MAX_BEATS=16 beats of +1 each, in_last never set → out_sum=16, out_beats=16, out_trunc=1. The next beat starts a fresh neuron.
- Backpressure and reset: hold out_ready=0 for 5 cycles → outputs stable and no beat accepted. Assert rst mid-accumulation of a second neuron → its partial sum is discarded, and the next neuron starts from 0.
